// File: rtl/cam_buf_pkg.sv
// rtl/cam_buf_pkg.sv - shared types, defaults and width helper for the camera buffer reader
package cam_buf_pkg;

   localparam int IMG_W_DEF = 480;
   localparam int IMG_H_DEF = 272;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_WAIT
   } rd_state_t;

   // Ceiling log2 with a floor of 1 so single-entry ranges still get a real bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cam_full_edge_sync.sv
// rtl/cam_full_edge_sync.sv - 2-FF synchronizer plus rising-edge pulse for one buffer-full level
module cam_full_edge_sync (
   input  logic iClk,
   input  logic wRsn,
   input  logic iFull,
   output logic oRise
);

   logic sync_1;
   logic sync_2;
   logic sync_2_q;

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_2_q <= 1'b0;
      end else begin
         sync_1   <= iFull;
         sync_2   <= sync_1;
         sync_2_q <= sync_2;
      end
   end

   assign oRise = sync_2 & ~sync_2_q;

endmodule

// File: rtl/cam_buf_rd_multi.sv
// rtl/cam_buf_rd_multi.sv - N-buffer ring read controller; raster markers built when CAM_BUF_RD_RASTER_MARK_EN is defined
module cam_buf_rd_multi
   import cam_buf_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int NBUF   = 2,
   parameter int ADDR_W = 17,
   parameter int RD_LAT = 1,
   parameter int DATA_W = 16
) (
   input  logic                          iClk,
   input  logic                          wRsn,
   input  logic                          wEnClk,
   input  logic [NBUF-1:0]               iBufFull,
   input  logic                          iFrDone,
   input  logic                          iRdReady,
   input  logic [DATA_W-1:0]             iBufRdDt,
   output logic                          oBufRdEn,
   output logic [ADDR_W-1:0]             oBufRdAddr,
   output logic [clog2_min1(NBUF)-1:0]   oBufSel,
   output logic [DATA_W-1:0]             oPixDt,
   output logic                          oPixValid,
   output logic                          oSof,
   output logic                          oEol,
   output logic                          oEof,
   output logic                          oRdDone,
   output logic [NBUF-1:0]               oBufRelease,
   output logic                          oOverrun
);

   localparam int SEL_W = clog2_min1(NBUF);
   localparam int COL_W = clog2_min1(IMG_W);
   localparam int ROW_W = clog2_min1(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NBUF - 1);

   rd_state_t          state;
   rd_state_t          state_n;
   logic [NBUF-1:0]    full_rise;
   logic [NBUF-1:0]    pending;
   logic [NBUF-1:0]    pend_clr;
   logic [SEL_W-1:0]   rd_ptr;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [ADDR_W-1:0]  addr;
   logic [RD_LAT-1:0]  vpipe;
   logic               start;
   logic               issue;
   logic               done_set;
   logic               rel_set;
   logic               is_last;

   for (genvar k = 0; k < NBUF; k++) begin : g_sync
      cam_full_edge_sync u_sync (
         .iClk  (iClk),
         .wRsn  (wRsn),
         .iFull (iBufFull[k]),
         .oRise (full_rise[k])
      );
   end

   assign is_last  = (col == COL_LAST) && (row == ROW_LAST);
   assign pend_clr = rel_set ? (NBUF'(1) << oBufSel) : '0;

   // Pending bookkeeping runs every iClk so one-cycle edge pulses are never lost.
   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         pending  <= '0;
         oOverrun <= 1'b0;
      end else begin
         pending <= (pending & ~pend_clr) | full_rise;
         if (|(full_rise & pending & ~pend_clr)) oOverrun <= 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      issue    = 1'b0;
      done_set = 1'b0;
      rel_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wEnClk && pending[rd_ptr]) begin
               start   = 1'b1;
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (wEnClk && iRdReady) begin
               issue = 1'b1;
               if (is_last) state_n = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (wEnClk && (vpipe == '0)) begin
               done_set = 1'b1;
               state_n  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wEnClk && iFrDone) begin
               rel_set = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign oBufRdEn   = issue;
   assign oBufRdAddr = addr;

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         col     <= '0;
         row     <= '0;
         addr    <= '0;
         oBufSel <= '0;
         rd_ptr  <= '0;
      end else begin
         if (start) begin
            oBufSel <= rd_ptr;
            col     <= '0;
            row     <= '0;
            addr    <= '0;
         end else if (issue && !is_last) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
         if (rel_set) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + SEL_W'(1);
      end
   end

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         oBufRelease <= '0;
         oRdDone     <= 1'b0;
      end else begin
         oBufRelease <= pend_clr;
         if (wEnClk) oRdDone <= done_set;
      end
   end

   // vpipe tracks in-flight reads; its last stage lines up with iBufRdDt.
   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         vpipe     <= '0;
         oPixValid <= 1'b0;
         oPixDt    <= '0;
      end else if (wEnClk) begin
         vpipe[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
         oPixValid <= vpipe[RD_LAT-1];
         if (vpipe[RD_LAT-1]) oPixDt <= iBufRdDt;
      end
   end

`ifdef CAM_BUF_RD_RASTER_MARK_EN
   logic [2:0] mark_pipe [RD_LAT];
   logic [2:0] mark_now;

   assign mark_now = {(col == '0) && (row == '0), col == COL_LAST, is_last};

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         for (int i = 0; i < RD_LAT; i++) mark_pipe[i] <= 3'b000;
         {oSof, oEol, oEof} <= 3'b000;
      end else if (wEnClk) begin
         mark_pipe[0] <= issue ? mark_now : 3'b000;
         for (int i = 1; i < RD_LAT; i++) mark_pipe[i] <= mark_pipe[i-1];
         {oSof, oEol, oEof} <= vpipe[RD_LAT-1] ? mark_pipe[RD_LAT-1] : 3'b000;
      end
   end
`else
   assign oSof = 1'b0;
   assign oEol = 1'b0;
   assign oEof = 1'b0;
`endif

endmodule

// File: tb/tb_cam_buf_rd_multi.sv
// tb/tb_cam_buf_rd_multi.sv - directed/randomized bench for cam_buf_rd_multi with a frame-level reference model
module tb_cam_buf_rd_multi;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 2;
   localparam int NBUF   = 3;
   localparam int ADDR_W = 3;
   localparam int RD_LAT = 2;
   localparam int DATA_W = 16;
   localparam int PIX    = IMG_W * IMG_H;

   logic              iClk = 1'b0;
   logic              wRsn;
   logic              wEnClk;
   logic [NBUF-1:0]   iBufFull;
   logic              iFrDone;
   logic              iRdReady;
   logic [DATA_W-1:0] iBufRdDt;
   logic              oBufRdEn;
   logic [ADDR_W-1:0] oBufRdAddr;
   logic [1:0]        oBufSel;
   logic [DATA_W-1:0] oPixDt;
   logic              oPixValid;
   logic              oSof;
   logic              oEol;
   logic              oEof;
   logic              oRdDone;
   logic [NBUF-1:0]   oBufRelease;
   logic              oOverrun;

   int checks   = 0;
   int failures = 0;
   int m_buf    = 0;
   int m_issue  = 0;
   int m_beat   = 0;
   int done_cnt = 0;
   int rel_cnt  = 0;
   logic en_q = 1'b0;
   logic [DATA_W-1:0] mem [4][8];
   logic [DATA_W-1:0] mem_d1 = '0;
   logic [DATA_W-1:0] mem_d2 = '0;
   logic [30:0] outs;
   bit seen;
   bit hit;

   cam_buf_rd_multi #(
      .IMG_W (IMG_W), .IMG_H (IMG_H), .NBUF (NBUF),
      .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .DATA_W(DATA_W)
   ) dut (
      .iClk       (iClk),
      .wRsn       (wRsn),
      .wEnClk     (wEnClk),
      .iBufFull   (iBufFull),
      .iFrDone    (iFrDone),
      .iRdReady   (iRdReady),
      .iBufRdDt   (iBufRdDt),
      .oBufRdEn   (oBufRdEn),
      .oBufRdAddr (oBufRdAddr),
      .oBufSel    (oBufSel),
      .oPixDt     (oPixDt),
      .oPixValid  (oPixValid),
      .oSof       (oSof),
      .oEol       (oEol),
      .oEof       (oEof),
      .oRdDone    (oRdDone),
      .oBufRelease(oBufRelease),
      .oOverrun   (oOverrun)
   );

   always #5 iClk = ~iClk;

   assign outs = {oBufRdEn, oBufRdAddr, oBufSel, oPixDt, oPixValid, oSof, oEol, oEof,
                  oRdDone, oBufRelease, oOverrun};

   // Frame memory with a two-enabled-cycle read latency.
   always @(posedge iClk) begin
      en_q <= wEnClk;
      if (wEnClk) begin
         mem_d1 <= oBufRdEn ? mem[oBufSel][oBufRdAddr] : '0;
         mem_d2 <= mem_d1;
      end
   end
   assign iBufRdDt = mem_d2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: frames in ring order, addresses 0..PIX-1, beat data from memory, markers by position.
   always @(negedge iClk) begin
      logic [2:0] exp_mark;
      if (!wRsn) begin
         m_buf   = 0;
         m_issue = 0;
         m_beat  = 0;
      end else begin
         if (oBufRdEn) begin
            chk("rd_addr", 32'(oBufRdAddr), 32'(m_issue));
            chk("rd_sel", 32'(oBufSel), 32'(m_buf));
            m_issue++;
         end
         if (en_q && oPixValid) begin
            if (m_beat < PIX) begin
`ifdef CAM_BUF_RD_RASTER_MARK_EN
               exp_mark = {m_beat == 0, (m_beat % IMG_W) == IMG_W - 1, m_beat == PIX - 1};
`else
               exp_mark = 3'b000;
`endif
               chk("pix_dt", 32'(oPixDt), 32'(mem[m_buf][m_beat]));
               chk("markers", 32'({oSof, oEol, oEof}), 32'(exp_mark));
            end else begin
               chk("extra_beat", 32'(m_beat), 32'(PIX - 1));
            end
            m_beat++;
         end
         if (en_q && oRdDone) begin
            chk("beats_at_done", 32'(m_beat), 32'(PIX));
            done_cnt++;
         end
         if (oBufRelease != '0) begin
            chk("release", 32'(oBufRelease), 32'(1 << m_buf));
            m_buf   = (m_buf + 1) % NBUF;
            m_issue = 0;
            m_beat  = 0;
            rel_cnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   // en_mode: 0 always enabled, 1 one-in-three; rdy_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
   task automatic run_frame(input int en_mode, input int rdy_mode, output bit done_seen);
      done_seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         wEnClk = (en_mode == 0) ? 1'b1 : ((c % 3) == 0);
         case (rdy_mode)
            0:       iRdReady = 1'b1;
            1:       iRdReady = ((c % 4) == 0) || ((c % 4) == 3);
            default: iRdReady = 1'($urandom_range(0, 1));
         endcase
         step(1);
         if (oRdDone) begin
            done_seen = 1'b1;
            break;
         end
      end
      wEnClk   = 1'b1;
      iRdReady = 1'b1;
   endtask

   task automatic release_frame();
      wEnClk  = 1'b1;
      iFrDone = 1'b1;
      step(1);
      iFrDone = 1'b0;
      step(2);
   endtask

   initial begin
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 8; a++) mem[b][a] = 16'($urandom);
      wRsn = 1'b0; wEnClk = 1'b0; iBufFull = '0; iFrDone = 1'b0; iRdReady = 1'b0;
      step(3);
      chk("reset_outputs", 32'(outs), 32'd0);
      wRsn = 1'b1; wEnClk = 1'b1; iRdReady = 1'b1;
      step(2);

      // Buffer 0 at full rate; buffers 1 and 2 fill while it is read.
      iBufFull[0] = 1'b1;
      step(6);
      iBufFull[1] = 1'b1;
      step(2);
      iBufFull[2] = 1'b1;
      run_frame(0, 0, seen);
      chk("done_buf0", 32'(seen), 32'd1);
      chk("overrun_idle", 32'(oOverrun), 32'd0);
      release_frame();
      iBufFull[0] = 1'b0;
      run_frame(0, 2, seen);
      chk("done_buf1", 32'(seen), 32'd1);
      release_frame();
      iBufFull[1] = 1'b0;
      run_frame(0, 0, seen);
      chk("done_buf2", 32'(seen), 32'd1);
      release_frame();
      iBufFull[2] = 1'b0;
      chk("rel_cnt_ring", 32'(rel_cnt), 32'd3);

      // Ring wrapped to buffer 0: stall, second full edge while pending, then toggled ready.
      iRdReady = 1'b0;
      step(4);
      iBufFull[0] = 1'b1;
      step(6);
      chk("overrun_pre", 32'(oOverrun), 32'd0);
      iBufFull[0] = 1'b0;
      step(4);
      iBufFull[0] = 1'b1;
      step(5);
      chk("overrun_set", 32'(oOverrun), 32'd1);
      run_frame(0, 1, seen);
      chk("done_toggle", 32'(seen), 32'd1);
      release_frame();
      iBufFull[0] = 1'b0;
      chk("overrun_held", 32'(oOverrun), 32'd1);

      // Sparse clock enable, full edge arriving while disabled.
      wEnClk = 1'b0;
      iBufFull[1] = 1'b1;
      step(5);
      run_frame(1, 2, seen);
      chk("done_sparse_en", 32'(seen), 32'd1);
      release_frame();
      iBufFull[1] = 1'b0;
      chk("rel_cnt_mid", 32'(rel_cnt), 32'd5);

      // Reset in the middle of buffer 2 at address 5.
      wEnClk = 1'b1; iRdReady = 1'b1;
      iBufFull[2] = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step(1);
         if (oBufRdAddr == ADDR_W'(5)) begin
            hit = 1'b1;
            break;
         end
      end
      chk("addr5_reached", 32'(hit), 32'd1);
      wRsn = 1'b0;
      iBufFull = '0;
      #1;
      chk("reset_mid_outputs", 32'(outs), 32'd0);
      step(3);
      chk("reset_hold_outputs", 32'(outs), 32'd0);
      chk("rel_cnt_reset", 32'(rel_cnt), 32'd5);
      wRsn = 1'b1;
      step(2);
      iBufFull[0] = 1'b1;
      run_frame(0, 0, seen);
      chk("done_after_reset", 32'(seen), 32'd1);
      release_frame();
      iBufFull[0] = 1'b0;
      chk("rel_cnt_final", 32'(rel_cnt), 32'd6);
      chk("done_cnt_final", 32'(done_cnt), 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
